// File: rtl/vdp_cpu_port_ctrl.sv
// vdp_cpu_port_ctrl
// -----------------
// Sequences Z8S180 I/O accesses to the two VDP CPU ports: the data port
// (port_sel=0) and the control port (port_sel=1).
// - Implements the TMS9918-style two-byte control latch.
// - Generates register write strobes.
// - Manages the VRAM address with auto-increment.
// - Maintains the read-ahead buffer.
// - Drives a req/ack handshake toward the VRAM arbiter.
//
// All state changes on the falling edge of phi. Reset is synchronous and
// active-high.
//
// Ports:
//   phi, reset               clock (falling edge active) / sync reset
//   wr_tick, rd_tick         one-cycle CPU write / read strobes
//   port_sel                 0=data port, 1=control port
//   cpu_wdata                CPU write byte
//   cpu_rdata                byte presented to the CPU bus mux
//   status_in, status_rd     VDP status byte / status-read pulse
//   reg_we, reg_num,
//   reg_data                 VDP register write strobe and payload
//   vram_req, vram_we,
//   vram_addr, vram_wdata    VRAM request, held until vram_ack
//   vram_rdata, vram_ack     VRAM read data / access complete
//   overrun                  sticky, a data-port access was dropped
//
// Optional feature macro: VDP_FIRST_BYTE_ADDR_EN
//   When defined, the first control byte also loads addr[7:0] immediately
//   (TMS9918 quirk). When undefined, the first byte only loads the latch.

module vdp_cpu_port_ctrl #(
   parameter int VRAM_AW   = 14,
   parameter int REG_NUM_W = 3
) (
   input  logic                 phi,
   input  logic                 reset,
   input  logic                 wr_tick,
   input  logic                 rd_tick,
   input  logic                 port_sel,
   input  logic [7:0]           cpu_wdata,
   output logic [7:0]           cpu_rdata,
   input  logic [7:0]           status_in,
   output logic                 status_rd,
   output logic                 reg_we,
   output logic [REG_NUM_W-1:0] reg_num,
   output logic [7:0]           reg_data,
   output logic                 vram_req,
   output logic                 vram_we,
   output logic [VRAM_AW-1:0]   vram_addr,
   output logic [7:0]           vram_wdata,
   input  logic [7:0]           vram_rdata,
   input  logic                 vram_ack,
   output logic                 overrun
);

   typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;

   state_t               state, state_next;
   logic [VRAM_AW-1:0]   addr, addr_ctrl, cur_addr;
   logic [7:0]           latch, read_buf, cur_wdata, pend_data, issue_data;
   logic                 second_byte, skip_inc;
   logic                 pend_valid, pend_we;
   logic                 issue_now, issue_we, to_slot, drop;
   logic                 wr, rd, ctrl_wr, ctrl_rd, data_wr, data_rd;
   logic                 first_wr, second_wr, set_addr, addr_set_any, ctrl_ra;
   logic                 new_op, ack_done;
   logic [13:0]          addr14;

   // A write wins over a simultaneous read; the read is simply ignored.
   assign wr        = wr_tick;
   assign rd        = rd_tick & ~wr_tick;
   assign ctrl_wr   = wr & port_sel;
   assign data_wr   = wr & ~port_sel;
   assign ctrl_rd   = rd & port_sel;
   assign data_rd   = rd & ~port_sel;
   assign first_wr  = ctrl_wr & ~second_byte;
   assign second_wr = ctrl_wr & second_byte;
   assign set_addr  = second_wr & ~cpu_wdata[7];
   assign ctrl_ra   = set_addr & ~cpu_wdata[6];
   assign new_op    = data_wr | data_rd | ctrl_ra;
   assign ack_done  = (state != IDLE) & vram_ack;
   assign addr14    = {cpu_wdata[5:0], latch};

`ifdef VDP_FIRST_BYTE_ADDR_EN
   assign addr_set_any = set_addr | first_wr;
`else
   assign addr_set_any = set_addr;
`endif

   // Address as modified by this edge's control write (ack increment aside).
   // Any access issued on this edge uses it, so a read-ahead queued by an
   // address-setting control write reads the newly set address.
   always_comb begin
      addr_ctrl = addr;
      if (set_addr)
         addr_ctrl = VRAM_AW'(addr14);
`ifdef VDP_FIRST_BYTE_ADDR_EN
      else if (first_wr)
         addr_ctrl[7:0] = cpu_wdata;
`endif
   end

   // State register for the VRAM request sequencer.
   always_ff @(negedge phi) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic and queue decisions. When idle, a pending slot entry
   // issues first and a new op then refills the slot. Otherwise a new op
   // issues directly. While a request is outstanding, a new op goes to the
   // one-deep slot, or is dropped when the slot is full. The slot takes the
   // live address at issue, which by then already includes the completed
   // access's increment.
   always_comb begin
      state_next = state;
      issue_now  = 1'b0;
      issue_we   = 1'b0;
      issue_data = 8'h00;
      to_slot    = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (pend_valid) begin
               issue_now  = 1'b1;
               issue_we   = pend_we;
               issue_data = pend_data;
               to_slot    = new_op;
            end else if (new_op) begin
               issue_now  = 1'b1;
               issue_we   = data_wr;
               issue_data = cpu_wdata;
            end
            if (issue_now)
               state_next = issue_we ? WR_REQ : RD_REQ;
         end
         default: begin
            if (ack_done)
               state_next = IDLE;
            if (new_op) begin
               if (pend_valid)
                  drop = 1'b1;
               else
                  to_slot = 1'b1;
            end
         end
      endcase
   end

   // Datapath: address and latch, read buffer, CPU-facing registers,
   // pending slot and the in-flight request snapshot.
   always_ff @(negedge phi) begin
      if (reset) begin
         addr        <= '0;
         latch       <= 8'h00;
         read_buf    <= 8'h00;
         second_byte <= 1'b0;
         skip_inc    <= 1'b0;
         cpu_rdata   <= 8'h00;
         status_rd   <= 1'b0;
         reg_we      <= 1'b0;
         reg_num     <= '0;
         reg_data    <= 8'h00;
         pend_valid  <= 1'b0;
         pend_we     <= 1'b0;
         pend_data   <= 8'h00;
         cur_addr    <= '0;
         cur_wdata   <= 8'h00;
         overrun     <= 1'b0;
      end else begin
         // A control write that moves the address during a request keeps
         // that address; the completing ack must not increment it.
         if (addr_set_any)
            addr <= addr_ctrl;
         else if (ack_done && !skip_inc)
            addr <= addr + 1'b1;

         if (ack_done)
            skip_inc <= 1'b0;
         else if (addr_set_any && state != IDLE)
            skip_inc <= 1'b1;

         if (first_wr)
            latch <= cpu_wdata;

         if (ctrl_wr)
            second_byte <= ~second_byte;
         else if (rd || data_wr)
            second_byte <= 1'b0;

         reg_we <= second_wr & cpu_wdata[7];
         if (second_wr && cpu_wdata[7]) begin
            reg_num  <= cpu_wdata[REG_NUM_W-1:0];
            reg_data <= latch;
         end

         if (data_wr)
            read_buf <= cpu_wdata;
         else if (ack_done && state == RD_REQ)
            read_buf <= vram_rdata;

         status_rd <= ctrl_rd;
         if (ctrl_rd)
            cpu_rdata <= status_in;
         else if (data_rd)
            cpu_rdata <= read_buf;

         if (to_slot) begin
            pend_valid <= 1'b1;
            pend_we    <= data_wr;
            pend_data  <= cpu_wdata;
         end else if (issue_now) begin
            pend_valid <= 1'b0;
         end

         if (issue_now) begin
            cur_addr  <= addr_ctrl;
            cur_wdata <= issue_data;
         end

         if (drop && (data_wr || data_rd))
            overrun <= 1'b1;
      end
   end

   assign vram_req   = (state != IDLE);
   assign vram_we    = (state == WR_REQ);
   assign vram_addr  = cur_addr;
   assign vram_wdata = cur_wdata;

endmodule

// File: tb/tb_vdp_cpu_port_ctrl.sv
// Testbench for vdp_cpu_port_ctrl: directed scenarios with hand-computed
// expected values. Inputs change just after a falling phi edge; outputs are
// sampled 1 time unit after the falling edge that updates them.

module tb_vdp_cpu_port_ctrl;

   logic        phi = 1'b1;
   logic        reset = 1'b1;
   logic        wr_tick = 1'b0;
   logic        rd_tick = 1'b0;
   logic        port_sel = 1'b0;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  cpu_rdata;
   logic [7:0]  status_in = 8'h00;
   logic        status_rd;
   logic        reg_we;
   logic [2:0]  reg_num;
   logic [7:0]  reg_data;
   logic        vram_req;
   logic        vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata = 8'h00;
   logic        vram_ack = 1'b0;
   logic        overrun;

   int checks = 0;
   int failures = 0;

   vdp_cpu_port_ctrl #(.VRAM_AW(14), .REG_NUM_W(3)) dut (
      .phi(phi), .reset(reset), .wr_tick(wr_tick), .rd_tick(rd_tick),
      .port_sel(port_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .status_in(status_in), .status_rd(status_rd), .reg_we(reg_we),
      .reg_num(reg_num), .reg_data(reg_data), .vram_req(vram_req),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
      .vram_rdata(vram_rdata), .vram_ack(vram_ack), .overrun(overrun)
   );

   always #5 phi = ~phi;

   task automatic step();
      @(negedge phi);
      #1;
   endtask

   task automatic cpu_write(input logic port, input logic [7:0] data);
      wr_tick = 1'b1; port_sel = port; cpu_wdata = data;
      step();
      wr_tick = 1'b0;
   endtask

   task automatic cpu_read(input logic port);
      rd_tick = 1'b1; port_sel = port;
      step();
      rd_tick = 1'b0;
   endtask

   task automatic ack_once(input logic [7:0] rdata);
      vram_ack = 1'b1; vram_rdata = rdata;
      step();
      vram_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %0h want 0", vram_req); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %0h want 0", overrun); end
      checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_reg_we: got %0h want 0", reg_we); end
      checks++; if (status_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_status_rd: got %0h want 0", status_rd); end
      checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_cpu_rdata: got %0h want 0", cpu_rdata); end
   endtask

   task automatic test_reg_write();
      cpu_write(1'b1, 8'h07);
      checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL reg_first_byte: got reg_we=%0h want 0", reg_we); end
      cpu_write(1'b1, 8'h81);
      checks++; if (reg_we !== 1'b1) begin failures++; $display("[TB] FAIL reg_we_pulse: got %0h want 1", reg_we); end
      checks++; if (reg_num !== 3'd1) begin failures++; $display("[TB] FAIL reg_num: got %0h want 1", reg_num); end
      checks++; if (reg_data !== 8'h07) begin failures++; $display("[TB] FAIL reg_data: got %0h want 07", reg_data); end
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL reg_no_req: got %0h want 0", vram_req); end
      step();
      checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL reg_we_one_cycle: got %0h want 0", reg_we); end
   endtask

   task automatic test_vram_write();
      cpu_write(1'b1, 8'h00);
      cpu_write(1'b1, 8'h40);
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL wsetup_no_req: got %0h want 0", vram_req); end
      cpu_write(1'b0, 8'hAA);
      cpu_write(1'b0, 8'h55);
      checks++; if ({vram_req, vram_we, vram_addr, vram_wdata} !== {1'b1, 1'b1, 14'h0000, 8'hAA}) begin
         failures++; $display("[TB] FAIL wr1_req: got req=%0h we=%0h addr=%0h data=%0h want 1 1 0000 AA", vram_req, vram_we, vram_addr, vram_wdata); end
      ack_once(8'h00);
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL wr1_idle_gap: got %0h want 0", vram_req); end
      step();
      checks++; if ({vram_req, vram_we, vram_addr, vram_wdata} !== {1'b1, 1'b1, 14'h0001, 8'h55}) begin
         failures++; $display("[TB] FAIL wr2_req: got req=%0h we=%0h addr=%0h data=%0h want 1 1 0001 55", vram_req, vram_we, vram_addr, vram_wdata); end
      step();
      ack_once(8'h00);
      cpu_read(1'b0);
      checks++; if (cpu_rdata !== 8'h55) begin failures++; $display("[TB] FAIL wr_readbuf: got %0h want 55", cpu_rdata); end
      checks++; if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h0002}) begin
         failures++; $display("[TB] FAIL wr_addr_after: got req=%0h we=%0h addr=%0h want 1 0 0002", vram_req, vram_we, vram_addr); end
      ack_once(8'h11);
   endtask

   task automatic test_read_setup();
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h12);
      checks++; if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h1234}) begin
         failures++; $display("[TB] FAIL rd_setup_req: got req=%0h we=%0h addr=%0h want 1 0 1234", vram_req, vram_we, vram_addr); end
      ack_once(8'h9C);
      cpu_read(1'b0);
      checks++; if (cpu_rdata !== 8'h9C) begin failures++; $display("[TB] FAIL rd_data: got %0h want 9C", cpu_rdata); end
      checks++; if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 14'h1235}) begin
         failures++; $display("[TB] FAIL rd_next_req: got req=%0h we=%0h addr=%0h want 1 0 1235", vram_req, vram_we, vram_addr); end
      ack_once(8'h00);
   endtask

   task automatic test_wrap();
      cpu_write(1'b1, 8'hFF);
      cpu_write(1'b1, 8'h7F);
      cpu_write(1'b0, 8'hA5);
      checks++; if (vram_addr !== 14'h3FFF) begin failures++; $display("[TB] FAIL wrap_top: got %0h want 3FFF", vram_addr); end
      ack_once(8'h00);
      cpu_read(1'b0);
      checks++; if (vram_addr !== 14'h0000) begin failures++; $display("[TB] FAIL wrap_zero: got %0h want 0000", vram_addr); end
      checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("[TB] FAIL wrap_readbuf: got %0h want A5", cpu_rdata); end
      ack_once(8'h00);
   endtask

   task automatic test_overrun();
      cpu_write(1'b1, 8'h00);
      cpu_write(1'b1, 8'h50);
      cpu_write(1'b0, 8'h11);
      cpu_write(1'b0, 8'h22);
      checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_not_yet: got %0h want 0", overrun); end
      cpu_write(1'b0, 8'h33);
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_set: got %0h want 1", overrun); end
      step();
      checks++; if ({vram_req, vram_addr, vram_wdata} !== {1'b1, 14'h1000, 8'h11}) begin
         failures++; $display("[TB] FAIL ovr_hold: got req=%0h addr=%0h data=%0h want 1 1000 11", vram_req, vram_addr, vram_wdata); end
      ack_once(8'h00);
      step();
      checks++; if ({vram_req, vram_addr, vram_wdata} !== {1'b1, 14'h1001, 8'h22}) begin
         failures++; $display("[TB] FAIL ovr_second: got req=%0h addr=%0h data=%0h want 1 1001 22", vram_req, vram_addr, vram_wdata); end
      ack_once(8'h00);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL ovr_third_dropped: got req=%0h want 0 (cycle %0d)", vram_req, i); end
      end
      checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_sticky: got %0h want 1", overrun); end
   endtask

   task automatic test_status_read();
      cpu_write(1'b1, 8'h07);
      status_in = 8'hA3;
      cpu_read(1'b1);
      checks++; if (status_rd !== 1'b1) begin failures++; $display("[TB] FAIL st_pulse: got %0h want 1", status_rd); end
      checks++; if (cpu_rdata !== 8'hA3) begin failures++; $display("[TB] FAIL st_data: got %0h want A3", cpu_rdata); end
      step();
      checks++; if (status_rd !== 1'b0) begin failures++; $display("[TB] FAIL st_one_cycle: got %0h want 0", status_rd); end
      cpu_write(1'b1, 8'h81);
      checks++; if (reg_we !== 1'b0) begin failures++; $display("[TB] FAIL st_clears_second: got reg_we=%0h want 0", reg_we); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      wr_tick = 1'b1; rd_tick = 1'b1; port_sel = 1'b1; cpu_wdata = 8'h5A;
      step();
      wr_tick = 1'b0; rd_tick = 1'b0;
      checks++; if (status_rd !== 1'b0) begin failures++; $display("[TB] FAIL sim_read_ignored: got %0h want 0", status_rd); end
      cpu_write(1'b1, 8'h82);
      checks++; if ({reg_we, reg_num, reg_data} !== {1'b1, 3'd2, 8'h5A}) begin
         failures++; $display("[TB] FAIL sim_write_wins: got we=%0h num=%0h data=%0h want 1 2 5A", reg_we, reg_num, reg_data); end
   endtask

   task automatic test_addr_override();
      do_reset();
      cpu_write(1'b0, 8'h66);
      cpu_write(1'b1, 8'h00);
      cpu_write(1'b1, 8'h48);
      checks++; if ({vram_req, vram_addr} !== {1'b1, 14'h0000}) begin
         failures++; $display("[TB] FAIL ovrd_inflight: got req=%0h addr=%0h want 1 0000", vram_req, vram_addr); end
      ack_once(8'h00);
      cpu_read(1'b0);
      checks++; if (vram_addr !== 14'h0800) begin failures++; $display("[TB] FAIL ovrd_no_inc: got %0h want 0800", vram_addr); end
      checks++; if (cpu_rdata !== 8'h66) begin failures++; $display("[TB] FAIL ovrd_readbuf: got %0h want 66", cpu_rdata); end
      ack_once(8'h00);
   endtask

   task automatic test_reset_mid();
      cpu_write(1'b0, 8'h10);
      cpu_write(1'b0, 8'h20);
      checks++; if (vram_req !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_pre: got %0h want 1", vram_req); end
      reset = 1'b1;
      step();
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_drop: got %0h want 0", vram_req); end
      reset = 1'b0;
      step();
      step();
      checks++; if (vram_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_pending_gone: got %0h want 0", vram_req); end
   endtask

   initial begin
      test_reset();
      test_reg_write();
      test_vram_write();
      test_read_setup();
      test_wrap();
      test_overrun();
      test_status_read();
      test_simultaneous();
      test_addr_override();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
